// File: rtl/gpio_cfg_serializer_pkg.sv
// Shared constants and the FSM state type for the GPIO pad-configuration
// serializer. Every pad carries the same word width and reset value.
package gpio_cfg_pkg;

    localparam int PAD_CTRL_BITS = 12;
    localparam logic [PAD_CTRL_BITS-1:0] GPIO_DEFAULT = 12'hC00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        LSETUP = 2'd2,
        LOAD   = 2'd3
    } cfg_state_t;

endpackage

// File: rtl/gpio_cfg_serializer_if.sv
// Management-side bus of the serializer: config word write/read port and
// transfer control.
//
// Handshake: the master requests a transfer by holding xfer_start high.
// The request is taken on the first clock edge where the slave is idle
// (xfer_busy low). xfer_busy rises on the following cycle and stays high
// until the transfer ends. xfer_done then pulses for one cycle, in the same
// cycle that xfer_busy falls. A request made while busy is dropped, not
// queued. Config writes have no back-pressure. A write made while busy, or
// to an address outside the pad range, is dropped and reported by a
// one-cycle cfg_wr_err pulse on the next cycle.
interface gpio_cfg_serializer_if #(
    parameter int NUM_PADS = 15
);
    import gpio_cfg_pkg::*;

    localparam int AW = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;

    logic                     cfg_wr_en;
    logic [AW-1:0]            cfg_wr_addr;
    logic [PAD_CTRL_BITS-1:0] cfg_wr_data;
    logic [PAD_CTRL_BITS-1:0] cfg_rd_data;
    logic                     cfg_wr_err;
    logic                     xfer_start;
    logic                     xfer_busy;
    logic                     xfer_done;
    cfg_state_t               dbg_state;

    modport master (
        output cfg_wr_en, cfg_wr_addr, cfg_wr_data, xfer_start,
        input  cfg_rd_data, cfg_wr_err, xfer_busy, xfer_done, dbg_state
    );

    modport slave (
        input  cfg_wr_en, cfg_wr_addr, cfg_wr_data, xfer_start,
        output cfg_rd_data, cfg_wr_err, xfer_busy, xfer_done, dbg_state
    );

endinterface

// File: rtl/gpio_cfg_serializer_clkdiv.sv
// Half-period timer for the chain shift clock. While enabled it emits a
// tick on the last mclk cycle of every CLK_DIV-cycle half period. The phase
// output says which half is in progress (0 = low half, 1 = high half).
// Disabling the timer returns it to the start of a low half.
module gpio_cfg_clkdiv #(
    parameter int CLK_DIV = 4
) (
    input  logic mclk,
    input  logic reset_n,
    input  logic enable,
    output logic tick,
    output logic phase
);

    localparam int CW = $clog2(CLK_DIV + 1);

    logic [CW-1:0] div_cnt;

    assign tick = enable && (div_cnt == CW'(CLK_DIV - 1));

    // Count mclk cycles within a half period and flip phase at each tick.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            phase   <= 1'b0;
        end else if (!enable) begin
            div_cnt <= '0;
            phase   <= 1'b0;
        end else if (tick) begin
            div_cnt <= '0;
            phase   <= ~phase;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/gpio_cfg_serializer.sv
// GPIO pad-configuration chain master. Holds one config word per pad. On
// request it shifts all words, pad NUM_PADS-1 first and MSB first, into the
// daisy-chained pad blocks, then strobes serial_load so every pad latches
// its word.
module gpio_cfg_serializer
    import gpio_cfg_pkg::*;
#(
    parameter int NUM_PADS = 15,
    parameter int CLK_DIV  = 4
) (
    input  logic                  mclk,
    input  logic                  reset_n,
    gpio_cfg_serializer_if.slave  bus,
    output logic                  serial_resetn,
    output logic                  serial_clock,
    output logic                  serial_data,
    output logic                  serial_load
);

    localparam int AW    = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;
    localparam int TOTAL = NUM_PADS * PAD_CTRL_BITS;
    localparam int BW    = $clog2(TOTAL + 1);

    logic [PAD_CTRL_BITS-1:0] cfg_q [NUM_PADS];
    logic [TOTAL-1:0]         snap;
    logic [TOTAL-1:0]         shreg;
    logic [BW-1:0]            bit_cnt;
    cfg_state_t               state;
    logic                     addr_ok;
    logic                     wr_ok;
    logic                     tick;
    logic                     phase;

    // The pad chain is reset directly by the system reset.
    assign serial_resetn = reset_n;
    // The outgoing bit is always the top of the shift register. The register
    // is cleared whenever the FSM is idle, so the data line then rests low.
    assign serial_data   = shreg[TOTAL-1];
    assign bus.dbg_state = state;

    assign addr_ok = ({1'b0, bus.cfg_wr_addr} < (AW + 1)'(NUM_PADS));
    assign wr_ok   = bus.cfg_wr_en && (state == IDLE) && addr_ok;

    gpio_cfg_clkdiv #(
        .CLK_DIV (CLK_DIV)
    ) u_clkdiv (
        .mclk    (mclk),
        .reset_n (reset_n),
        .enable  (state != IDLE),
        .tick    (tick),
        .phase   (phase)
    );

    // Config register file: accept writes only when idle and in range.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PADS; i++) cfg_q[i] <= GPIO_DEFAULT;
        end else if (wr_ok) begin
            cfg_q[bus.cfg_wr_addr] <= bus.cfg_wr_data;
        end
    end

    // Flag rejected writes with a one-cycle pulse.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) bus.cfg_wr_err <= 1'b0;
        else          bus.cfg_wr_err <= bus.cfg_wr_en && !wr_ok;
    end

    // Read port is combinational. It returns zero for out-of-range addresses.
    always_comb begin
        bus.cfg_rd_data = '0;
        if (addr_ok) bus.cfg_rd_data = cfg_q[bus.cfg_wr_addr];
    end

    // Build the chain image: pad NUM_PADS-1 occupies the top (first-out) bits.
    always_comb begin
        snap = '0;
        for (int p = 0; p < NUM_PADS; p++)
            snap[p*PAD_CTRL_BITS +: PAD_CTRL_BITS] = cfg_q[p];
    end

    // Transfer FSM: shift every bit, hold data for load setup, strobe load,
    // then report completion.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            shreg         <= '0;
            bit_cnt       <= '0;
            serial_clock  <= 1'b0;
            serial_load   <= 1'b0;
            bus.xfer_busy <= 1'b0;
            bus.xfer_done <= 1'b0;
        end else begin
            bus.xfer_done <= 1'b0;
            case (state)
                IDLE: begin
                    serial_clock <= 1'b0;
                    serial_load  <= 1'b0;
                    if (bus.xfer_start) begin
                        state         <= SHIFT;
                        shreg         <= snap;
                        bit_cnt       <= '0;
                        bus.xfer_busy <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (!phase) begin
                            serial_clock <= 1'b1;
                        end else begin
                            // Falling edge: advance to the next bit unless this was the last.
                            serial_clock <= 1'b0;
                            if (bit_cnt == BW'(TOTAL - 1)) begin
                                state <= LSETUP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                shreg   <= {shreg[TOTAL-2:0], 1'b0};
                            end
                        end
                    end
                end
                LSETUP: begin
                    if (tick) begin
                        state       <= LOAD;
                        serial_load <= 1'b1;
                    end
                end
                LOAD: begin
                    if (tick) begin
                        state         <= IDLE;
                        serial_load   <= 1'b0;
                        shreg         <= '0;
                        bus.xfer_busy <= 1'b0;
                        bus.xfer_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_cfg_serializer.sv
// Bench for gpio_cfg_serializer: two instances (CLK_DIV=2 and CLK_DIV=1)
// each drive a modelled chain of 15 pad receivers. Expected pad contents
// are queued when a transfer starts and compared when the load completes.
module tb_gpio_cfg_serializer;
    import gpio_cfg_pkg::*;

    localparam int NP  = 15;
    localparam int B   = 12;
    localparam int TOT = NP * B;

    typedef struct packed {
        int           rises;
        int           loads;
        int           busy_cyc;
        int           load_cyc;
        int           viol;
        logic [TOT-1:0] latched;
        logic [TOT-1:0] chain;
    } mon_t;

    // ---------------- clock / reset ----------------
    logic mclk = 1'b0;
    logic reset_n;
    always #5 mclk = ~mclk;

    int compared   = 0;
    int mismatched = 0;
    logic [B-1:0] exp_q [$];
    logic [B-1:0] model [2][NP];

    gpio_cfg_serializer_if #(.NUM_PADS(NP)) bus_a ();
    gpio_cfg_serializer_if #(.NUM_PADS(NP)) bus_b ();

    wire [1:0] sresetn_w;
    wire [1:0] sclk_w;
    wire [1:0] sdata_w;
    wire [1:0] sload_w;
    wire [1:0] busy_w    = {bus_b.xfer_busy, bus_a.xfer_busy};
    wire [1:0] done_w    = {bus_b.xfer_done, bus_a.xfer_done};
    wire [1:0] err_w     = {bus_b.cfg_wr_err, bus_a.cfg_wr_err};
    wire [1:0] idle_w    = {bus_b.dbg_state == IDLE, bus_a.dbg_state == IDLE};
    wire [1:0] lstate_w  = {bus_b.dbg_state == LOAD, bus_a.dbg_state == LOAD};
    wire [B-1:0] rd_w [2];
    assign rd_w[0] = bus_a.cfg_rd_data;
    assign rd_w[1] = bus_b.cfg_rd_data;

    gpio_cfg_serializer #(.NUM_PADS(NP), .CLK_DIV(2)) dut_a (
        .mclk          (mclk),
        .reset_n       (reset_n),
        .bus           (bus_a),
        .serial_resetn (sresetn_w[0]),
        .serial_clock  (sclk_w[0]),
        .serial_data   (sdata_w[0]),
        .serial_load   (sload_w[0])
    );

    gpio_cfg_serializer #(.NUM_PADS(NP), .CLK_DIV(1)) dut_b (
        .mclk          (mclk),
        .reset_n       (reset_n),
        .bus           (bus_b),
        .serial_resetn (sresetn_w[1]),
        .serial_clock  (sclk_w[1]),
        .serial_data   (sdata_w[1]),
        .serial_load   (sload_w[1])
    );

    // ---------------- pad-chain receivers and protocol monitors ----------------
    for (genvar g = 0; g < 2; g++) begin : mon
        logic [TOT-1:0] chain   = '0;
        logic [TOT-1:0] latched = '0;
        int rises    = 0;
        int loads    = 0;
        int busy_cyc = 0;
        int load_cyc = 0;
        int clk_viol = 0;
        int lvl_viol = 0;
        mon_t snap;

        always @(posedge sclk_w[g] or negedge sresetn_w[g])
            if (!sresetn_w[g]) chain <= '0;
            else               chain <= {chain[TOT-2:0], sdata_w[g]};

        always @(posedge sload_w[g] or negedge sresetn_w[g])
            if (!sresetn_w[g]) latched <= '0;
            else               latched <= chain;

        always @(posedge sclk_w[g]) begin
            rises <= rises + 1;
            if (sload_w[g]) clk_viol <= clk_viol + 1;
        end

        always @(posedge sload_w[g]) loads <= loads + 1;

        always @(posedge mclk) begin
            busy_cyc <= busy_cyc + int'(busy_w[g]);
            load_cyc <= load_cyc + int'(sload_w[g]);
        end

        always @(negedge mclk)
            if ((sload_w[g] && !lstate_w[g]) ||
                (idle_w[g] && (sclk_w[g] || sdata_w[g] || sload_w[g])))
                lvl_viol <= lvl_viol + 1;

        always_comb begin
            snap.rises    = rises;
            snap.loads    = loads;
            snap.busy_cyc = busy_cyc;
            snap.load_cyc = load_cyc;
            snap.viol     = clk_viol + lvl_viol;
            snap.latched  = latched;
            snap.chain    = chain;
        end
    end

    function automatic mon_t mon_get(int d);
        return (d == 0) ? mon[0].snap : mon[1].snap;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_wr(int d, logic en, logic [3:0] addr, logic [B-1:0] data);
        if (d == 0) begin
            bus_a.cfg_wr_en = en; bus_a.cfg_wr_addr = addr; bus_a.cfg_wr_data = data;
        end else begin
            bus_b.cfg_wr_en = en; bus_b.cfg_wr_addr = addr; bus_b.cfg_wr_data = data;
        end
    endtask

    task automatic drive_start(int d, logic v);
        if (d == 0) bus_a.xfer_start = v;
        else        bus_b.xfer_start = v;
    endtask

    task automatic reset_model();
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < NP; p++) model[d][p] = 12'hC00;
    endtask

    task automatic write_cfg(int d, logic [3:0] addr, logic [B-1:0] data, logic exp_err);
        @(negedge mclk);
        drive_wr(d, 1'b1, addr, data);
        @(negedge mclk);
        drive_wr(d, 1'b0, addr, '0);
        compared++;
        if (err_w[d] !== exp_err) begin
            mismatched++;
            $display("FAIL wr_err d%0d addr%0d: got %b expected %b", d, addr, err_w[d], exp_err);
        end
        if (!exp_err) model[d][addr] = data;
    endtask

    task automatic check_reads(int d, string tag);
        for (int a = 0; a < NP; a++) begin
            @(negedge mclk);
            drive_wr(d, 1'b0, 4'(a), '0);
            #1;
            compared++;
            if (rd_w[d] !== model[d][a]) begin
                mismatched++;
                $display("FAIL %s rd d%0d pad%0d: got %h expected %h", tag, d, a, rd_w[d], model[d][a]);
            end
        end
    endtask

    task automatic begin_xfer(int d, output mon_t base);
        @(negedge mclk);
        base = mon_get(d);
        for (int p = 0; p < NP; p++) exp_q.push_back(model[d][p]);
        drive_start(d, 1'b1);
        @(negedge mclk);
        drive_start(d, 1'b0);
        compared++;
        if (busy_w[d] !== 1'b1) begin
            mismatched++;
            $display("FAIL busy_rise d%0d: got %b expected 1", d, busy_w[d]);
        end
    endtask

    task automatic finish_xfer(int d, mon_t base, int div);
        mon_t now;
        logic [B-1:0] w;
        int n = 0;
        while (done_w[d] !== 1'b1 && n < 5000) begin
            @(negedge mclk);
            n++;
        end
        compared++;
        if (n >= 5000) begin
            mismatched++;
            $display("FAIL done_timeout d%0d: got no done expected done", d);
            for (int p = 0; p < NP; p++) void'(exp_q.pop_front());
            return;
        end
        now = mon_get(d);
        compared += 6;
        if (now.busy_cyc - base.busy_cyc != TOT*2*div + 2*div) begin
            mismatched++;
            $display("FAIL busy_len d%0d: got %0d expected %0d", d, now.busy_cyc - base.busy_cyc, TOT*2*div + 2*div);
        end
        if (now.rises - base.rises != TOT) begin
            mismatched++;
            $display("FAIL clk_rises d%0d: got %0d expected %0d", d, now.rises - base.rises, TOT);
        end
        if (now.loads - base.loads != 1) begin
            mismatched++;
            $display("FAIL load_pulses d%0d: got %0d expected 1", d, now.loads - base.loads);
        end
        if (now.load_cyc - base.load_cyc != div) begin
            mismatched++;
            $display("FAIL load_width d%0d: got %0d expected %0d", d, now.load_cyc - base.load_cyc, div);
        end
        if (now.viol != base.viol) begin
            mismatched++;
            $display("FAIL protocol d%0d: got %0d violations expected 0", d, now.viol - base.viol);
        end
        if (busy_w[d] !== 1'b0) begin
            mismatched++;
            $display("FAIL busy_fall d%0d: got %b expected 0", d, busy_w[d]);
        end
        for (int p = 0; p < NP; p++) begin
            w = exp_q.pop_front();
            compared++;
            if (now.latched[p*B +: B] !== w) begin
                mismatched++;
                $display("FAIL pad d%0d pad%0d: got %h expected %h", d, p, now.latched[p*B +: B], w);
            end
            if (p == NP - 1) begin
                compared++;
                if (now.chain[TOT-1] !== w[B-1]) begin
                    mismatched++;
                    $display("FAIL first_bit d%0d: got %b expected %b", d, now.chain[TOT-1], w[B-1]);
                end
            end
        end
        @(negedge mclk);
        compared++;
        if (done_w[d] !== 1'b0) begin
            mismatched++;
            $display("FAIL done_width d%0d: got %b expected 0", d, done_w[d]);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge mclk);
        compared++;
        if (sresetn_w !== 2'b00) begin
            mismatched++;
            $display("FAIL serial_resetn_low: got %b expected 00", sresetn_w);
        end
        reset_n = 1'b1;
        @(negedge mclk);
        compared += 2;
        if ({sclk_w, sdata_w, sload_w, busy_w, done_w, err_w} !== 12'h0) begin
            mismatched++;
            $display("FAIL reset_outputs: got %h expected 000", {sclk_w, sdata_w, sload_w, busy_w, done_w, err_w});
        end
        if (sresetn_w !== 2'b11) begin
            mismatched++;
            $display("FAIL serial_resetn_high: got %b expected 11", sresetn_w);
        end
        check_reads(0, "reset");
    endtask

    task automatic test_default_xfer();
        mon_t base;
        begin_xfer(0, base);
        finish_xfer(0, base, 2);
    endtask

    task automatic test_written_xfer();
        mon_t base;
        write_cfg(0, 4'd3, 12'h5A5, 1'b0);
        write_cfg(0, 4'd14, 12'h001, 1'b0);
        check_reads(0, "written");
        begin_xfer(0, base);
        finish_xfer(0, base, 2);
    endtask

    task automatic test_busy_reject();
        mon_t base;
        mon_t later;
        begin_xfer(0, base);
        write_cfg(0, 4'd3, 12'h123, 1'b1);
        write_cfg(0, 4'd15, 12'h456, 1'b1);
        @(negedge mclk);
        drive_start(0, 1'b1);
        @(negedge mclk);
        drive_start(0, 1'b0);
        finish_xfer(0, base, 2);
        write_cfg(0, 4'd15, 12'hFFF, 1'b1);
        repeat (20) @(negedge mclk);
        later = mon_get(0);
        compared += 2;
        if (busy_w[0] !== 1'b0) begin
            mismatched++;
            $display("FAIL no_queue_busy: got %b expected 0", busy_w[0]);
        end
        if (later.loads - base.loads != 1) begin
            mismatched++;
            $display("FAIL no_queue_loads: got %0d expected 1", later.loads - base.loads);
        end
        check_reads(0, "busy_reject");
    endtask

    task automatic test_reset_mid();
        mon_t base;
        mon_t now;
        int n = 0;
        begin_xfer(0, base);
        now = mon_get(0);
        while (now.rises - base.rises < 50 && n < 2000) begin
            @(negedge mclk);
            now = mon_get(0);
            n++;
        end
        compared++;
        if (n >= 2000) begin
            mismatched++;
            $display("FAIL bit50_timeout: got %0d rises expected 50", now.rises - base.rises);
        end
        reset_n = 1'b0;
        #1;
        now = mon_get(0);
        compared += 3;
        if ({sclk_w[0], sdata_w[0], sload_w[0], busy_w[0], done_w[0]} !== 5'b0) begin
            mismatched++;
            $display("FAIL async_reset_outputs: got %b expected 00000", {sclk_w[0], sdata_w[0], sload_w[0], busy_w[0], done_w[0]});
        end
        if (now.loads != base.loads) begin
            mismatched++;
            $display("FAIL reset_no_load: got %0d loads expected 0", now.loads - base.loads);
        end
        if (now.latched !== '0) begin
            mismatched++;
            $display("FAIL reset_pads_cleared: got %h expected 0", now.latched[B-1:0]);
        end
        for (int p = 0; p < NP; p++) void'(exp_q.pop_front());
        reset_model();
        repeat (2) @(negedge mclk);
        reset_n = 1'b1;
        check_reads(0, "after_reset");
        begin_xfer(0, base);
        finish_xfer(0, base, 2);
    endtask

    task automatic test_fast_div();
        mon_t base;
        write_cfg(1, 4'd7, 12'hABC, 1'b0);
        write_cfg(1, 4'd0, 12'h3F0, 1'b0);
        begin_xfer(1, base);
        finish_xfer(1, base, 1);
    endtask

    initial begin
        reset_n = 1'b0;
        drive_wr(0, 1'b0, '0, '0);
        drive_wr(1, 1'b0, '0, '0);
        drive_start(0, 1'b0);
        drive_start(1, 1'b0);
        reset_model();
        test_reset();
        test_default_xfer();
        test_written_xfer();
        test_busy_reject();
        test_reset_mid();
        test_fast_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
